// File: rtl/rr_event_encoder.sv
// rr_event_encoder: sticky per-channel event capture with round-robin or fixed-priority grant over valid/ready
module rr_event_encoder #(
  parameter int input_width = 8,
  parameter int round_robin = 1,
  localparam int index_width = (input_width > 1) ? $clog2(input_width) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [input_width-1:0] request,
  input  logic                   ready,
  output logic                   valid,
  output logic [index_width-1:0] index,
  output logic [input_width-1:0] one_hot,
  output logic [input_width-1:0] pending,
  output logic                   collision
);
  localparam logic [input_width-1:0] one = 1;
  logic [index_width-1:0] last, sel;
  logic [input_width-1:0] cand, above, src;
  logic load;
  always_comb begin
    cand = pending | request;
    above = '0;
    for (int i = 0; i < input_width; i++) above[i[index_width-1:0]] = (round_robin != 0) && (i > int'(last));
    // channels after last win first; if none pending there, wrap to the lowest
    src = ((cand & above) != '0) ? (cand & above) : cand;
    sel = '0;
    for (int i = input_width - 1; i >= 0; i--) if (src[i[index_width-1:0]]) sel = i[index_width-1:0];
    load = (!valid || ready) && (cand != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      valid <= 1'b0;
      index <= '0;
      one_hot <= '0;
      collision <= 1'b0;
      last <= index_width'(input_width - 1);
    end else begin
      collision <= |(request & (pending | (valid ? one_hot : '0)));
      if (load) begin
        valid <= 1'b1;
        index <= sel;
        one_hot <= one << sel;
        last <= sel;
        pending <= cand & ~(one << sel);
      end else begin
        pending <= cand;
        if (valid && ready) begin
          valid <= 1'b0;
          one_hot <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rr_event_encoder.sv
// tb_rr_event_encoder: directed and randomized checks of rr_event_encoder against a behavioural model
module tb_rr_event_encoder;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [4:0] r5 = 0, rf = 0;
  logic [16:0] r17 = 0;
  logic rdy5 = 1, rdyf = 1, rdy17 = 1;
  logic v5, vf, v17, c5, cf, c17;
  logic [2:0] i5, ifx;
  logic [4:0] i17;
  logic [4:0] oh5, ohf, p5, pf;
  logic [16:0] oh17, p17;
  int checks = 0, errors = 0;

  rr_event_encoder #(.input_width(5), .round_robin(1)) d5 (.clk(clk), .reset(rst), .request(r5), .ready(rdy5),
    .valid(v5), .index(i5), .one_hot(oh5), .pending(p5), .collision(c5));
  rr_event_encoder #(.input_width(5), .round_robin(0)) f5 (.clk(clk), .reset(rst), .request(rf), .ready(rdyf),
    .valid(vf), .index(ifx), .one_hot(ohf), .pending(pf), .collision(cf));
  rr_event_encoder #(.input_width(17), .round_robin(1)) d17 (.clk(clk), .reset(rst), .request(r17), .ready(rdy17),
    .valid(v17), .index(i17), .one_hot(oh17), .pending(p17), .collision(c17));

  // reference model: pending set, output stage, last grant; one slot per instance
  int mw[3] = '{5, 5, 17};
  bit mrr[3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] mp[3];
  bit mv[3], mc[3];
  int mi[3], ml[3];

  function automatic void step(int k, logic [63:0] req, bit rdy);
    logic [63:0] cand;
    int sel;
    if (rst) begin
      mp[k] = 0; mv[k] = 0; mi[k] = 0; mc[k] = 0; ml[k] = mw[k] - 1;
      return;
    end
    mc[k] = (req & (mp[k] | (mv[k] ? (64'd1 << mi[k]) : 64'd0))) != 0;
    cand = mp[k] | req;
    sel = -1;
    if ((!mv[k] || rdy) && cand != 0) begin
      for (int n = 0; n < mw[k]; n++) begin
        int c = mrr[k] ? (ml[k] + 1 + n) % mw[k] : n;
        if (sel < 0 && ((cand >> c) & 64'd1) != 0) sel = c;
      end
      mv[k] = 1; mi[k] = sel; ml[k] = sel; mp[k] = cand & ~(64'd1 << sel);
    end else begin
      mp[k] = cand;
      if (mv[k] && rdy) mv[k] = 0;
    end
  endfunction

  task automatic tick();
    step(0, 64'(r5), rdy5);
    step(1, 64'(rf), rdyf);
    step(2, 64'(r17), rdy17);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; r5 = 5'b11111; r17 = '1;
    tick();
    rst = 0; r5 = 0; r17 = 0;
    checks++;
    if ({v5, i5, oh5, p5, c5} !== 15'd0) begin
      errors++; $display("FAIL reset5: got v=%b i=%0d oh=%b p=%b c=%b want all 0", v5, i5, oh5, p5, c5);
    end
    checks++;
    if ({v17, i17, oh17, p17, c17} !== 41'd0) begin
      errors++; $display("FAIL reset17: got v=%b i=%0d oh=%h p=%h want all 0", v17, i17, oh17, p17);
    end
  endtask

  task automatic test_rr_sequence();
    int ei[3] = '{1, 2, 4};
    logic [4:0] ep[3] = '{5'b10100, 5'b10000, 5'b00000};
    rdy5 = 1; r5 = 5'b10110;
    tick();
    r5 = 0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({v5, i5, oh5, p5} !== {1'b1, 3'(ei[n]), 5'(5'd1 << ei[n]), ep[n]}) begin
        errors++; $display("FAIL rr_seq%0d: got v=%b i=%0d oh=%b p=%b want i=%0d p=%b", n, v5, i5, oh5, p5, ei[n], ep[n]);
      end
      tick();
    end
    checks++;
    if ({v5, oh5} !== 6'd0) begin
      errors++; $display("FAIL rr_empty: got v=%b oh=%b want 0", v5, oh5);
    end
    rst = 1; tick(); rst = 0;
    r5 = 5'b00100; tick(); r5 = 0; tick();
    r5 = 5'b00101; tick(); r5 = 0;
    checks++;
    if ({v5, i5} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rr_after2_a: got v=%b i=%0d want 1/0", v5, i5);
    end
    tick();
    checks++;
    if ({v5, i5} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL rr_after2_b: got v=%b i=%0d want 1/2", v5, i5);
    end
    tick();
    r5 = 5'b00011; tick();
    r5 = 5'b00001; tick(); r5 = 0;
    checks++;
    if (i5 !== 3'd1) begin
      errors++; $display("FAIL rr_rotate: got i=%0d want 1", i5);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_fixed();
    int ei[3] = '{1, 2, 4};
    rst = 1; tick(); rst = 0;
    rdyf = 1; rf = 5'b10110; tick(); rf = 0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({vf, ifx, ohf} !== {1'b1, 3'(ei[n]), 5'(5'd1 << ei[n])}) begin
        errors++; $display("FAIL fix_seq%0d: got v=%b i=%0d oh=%b want i=%0d", n, vf, ifx, ohf, ei[n]);
      end
      if (n == 2) rf = 5'b00010;
      tick();
      rf = 0;
    end
    checks++;
    if ({vf, ifx} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL fix_rereq: got v=%b i=%0d want 1/1", vf, ifx);
    end
    tick();
    rf = 5'b00011; tick();
    rf = 5'b00001; tick(); rf = 0;
    checks++;
    if (ifx !== 3'd0) begin
      errors++; $display("FAIL fix_lowest: got i=%0d want 0", ifx);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_stall();
    rst = 1; tick(); rst = 0;
    rdy5 = 0; r5 = 5'b00001; tick();
    r5 = 5'b00010; tick(); r5 = 0;
    checks++;
    if ({v5, i5, oh5, p5} !== {1'b1, 3'd0, 5'b00001, 5'b00010}) begin
      errors++; $display("FAIL stall_hold: got v=%b i=%0d oh=%b p=%b want 1/0/00001/00010", v5, i5, oh5, p5);
    end
    tick();
    checks++;
    if ({v5, i5, p5} !== {1'b1, 3'd0, 5'b00010}) begin
      errors++; $display("FAIL stall_hold2: got v=%b i=%0d p=%b", v5, i5, p5);
    end
    rdy5 = 1; tick();
    checks++;
    if ({v5, i5, oh5, p5} !== {1'b1, 3'd1, 5'b00010, 5'b00000}) begin
      errors++; $display("FAIL stall_release: got v=%b i=%0d oh=%b p=%b want 1/1", v5, i5, oh5, p5);
    end
    tick();
  endtask

  task automatic test_collision();
    int pulses = 0, grants3 = 0;
    rst = 1; tick(); rst = 0;
    rdy5 = 0;
    r5 = 5'b00001; tick();
    r5 = 5'b01000; tick();
    pulses += c5;
    r5 = 0; tick();
    pulses += c5;
    r5 = 5'b01000; tick();
    pulses += c5;
    checks++;
    if (c5 !== 1'b1) begin
      errors++; $display("FAIL coll_pulse: got c=%b want 1", c5);
    end
    r5 = 0; tick();
    pulses += c5;
    rdy5 = 1;
    for (int n = 0; n < 5; n++) begin
      tick();
      pulses += c5;
      if (v5 && i5 == 3'd3) grants3++;
    end
    checks++;
    if (pulses != 1 || grants3 != 1) begin
      errors++; $display("FAIL coll_count: got pulses=%0d grants3=%0d want 1/1", pulses, grants3);
    end
  endtask

  task automatic test_wide();
    rst = 1; tick(); rst = 0;
    rdy17 = 1; r17 = 17'h10000; tick();
    checks++;
    if ({v17, i17, oh17} !== {1'b1, 5'd16, 17'h10000}) begin
      errors++; $display("FAIL wide16: got v=%b i=%0d oh=%h want 1/16/10000", v17, i17, oh17);
    end
    r17 = 17'h00001; tick(); r17 = 0;
    checks++;
    if ({v17, i17, oh17} !== {1'b1, 5'd0, 17'h00001}) begin
      errors++; $display("FAIL wide_wrap: got v=%b i=%0d oh=%h want 1/0/00001", v17, i17, oh17);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rst = 1; tick(); rst = 0;
    rdy5 = 0; r5 = 5'b00001; tick();
    r5 = 5'b11000; tick();
    checks++;
    if ({v5, p5} !== {1'b1, 5'b11000}) begin
      errors++; $display("FAIL mid_setup: got v=%b p=%b want 1/11000", v5, p5);
    end
    rst = 1; r5 = 5'b00001; tick();
    rst = 0; r5 = 0;
    checks++;
    if ({v5, i5, oh5, p5, c5} !== 15'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b i=%0d oh=%b p=%b c=%b want all 0", v5, i5, oh5, p5, c5);
    end
    rdy5 = 1; tick();
    checks++;
    if ({v5, p5} !== 6'd0) begin
      errors++; $display("FAIL mid_dropped: got v=%b p=%b want 0", v5, p5);
    end
    r5 = 5'b00011; tick(); r5 = 0;
    checks++;
    if ({v5, i5} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL mid_restart: got v=%b i=%0d want 1/0", v5, i5);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    int bad = 0, badwide = 0;
    logic [63:0] oh;
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 10000; n++) begin
      r5 = 5'($urandom & $urandom);
      rf = 5'($urandom & $urandom);
      r17 = 17'($urandom & $urandom & $urandom);
      rdy5 = $urandom_range(0, 3) != 0;
      rdyf = $urandom_range(0, 2) != 0;
      rdy17 = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) == 0;
      tick();
      oh = mv[0] ? (64'd1 << mi[0]) : 64'd0;
      checks++;
      if ({v5, i5, oh5, p5, c5} !== {mv[0], 3'(mi[0]), 5'(oh), 5'(mp[0]), mc[0]}) begin
        errors++;
        if (bad++ < 5) $display("FAIL rand5 cyc %0d: got v=%b i=%0d oh=%b p=%b c=%b want v=%b i=%0d p=%b c=%b",
          n, v5, i5, oh5, p5, c5, mv[0], mi[0], 5'(mp[0]), mc[0]);
      end
      oh = mv[1] ? (64'd1 << mi[1]) : 64'd0;
      checks++;
      if ({vf, ifx, ohf, pf, cf} !== {mv[1], 3'(mi[1]), 5'(oh), 5'(mp[1]), mc[1]}) begin
        errors++;
        if (bad++ < 5) $display("FAIL randfix cyc %0d: got v=%b i=%0d oh=%b p=%b c=%b want v=%b i=%0d p=%b c=%b",
          n, vf, ifx, ohf, pf, cf, mv[1], mi[1], 5'(mp[1]), mc[1]);
      end
      oh = mv[2] ? (64'd1 << mi[2]) : 64'd0;
      checks++;
      if ({v17, i17, oh17, p17, c17} !== {mv[2], 5'(mi[2]), 17'(oh), 17'(mp[2]), mc[2]} || i17 > 5'd16) begin
        errors++;
        if (badwide++ < 5) $display("FAIL rand17 cyc %0d: got v=%b i=%0d oh=%h p=%h c=%b want v=%b i=%0d p=%h c=%b",
          n, v17, i17, oh17, p17, c17, mv[2], mi[2], 17'(mp[2]), mc[2]);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_fixed();
    test_stall();
    test_collision();
    test_wide();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
